// File: rtl/mem_port_arb_if.sv
`default_nettype none
// ============================================================================
// mem_port_arb_if : fetch, data and memory-side signals of mem_port_arb
// Rev 1.0
// ============================================================================
interface mem_port_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// mem_port_arb : fetch/data arbiter for the shared single-port memory.
// Optional watchdog enabled with macro ARB_WATCHDOG_EN.            Rev 1.0
// ============================================================================
module mem_port_arb #(
  parameter int FETCH_STARVE_MAX = 4,
  parameter int WDOG_CYCLES      = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_port_arb_if.master bus,
  output logic           bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [3:0]  c_starve_max = 4'(FETCH_STARVE_MAX);
  localparam logic [31:0] c_nop        = 32'h0000_0013;

  if (FETCH_STARVE_MAX < 1 || FETCH_STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arb: FETCH_STARVE_MAX must be within 1..15");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("mem_port_arb: WDOG_CYCLES must be at least 1");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_streak, w_streak_nxt;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        w_grant_if, w_grant_dm;
  logic        w_if_done, w_dm_done;
  logic        w_if_cand, w_busy, w_timeout;

  assign w_if_cand = bus.if_req & ~bus.if_flush;
  assign w_busy    = (r_state != IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_if_done    = 1'b0;
    w_dm_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_cand && (!bus.dm_req || r_streak == c_starve_max)) begin
          w_grant_if   = 1'b1;
          w_state_nxt  = BUSY_IF;
          w_streak_nxt = 4'd0;
        end else if (bus.dm_req) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = BUSY_DM;
          // Streak only counts data grants that actually made a fetch wait
          if (!bus.if_req)
            w_streak_nxt = 4'd0;
          else if (r_streak != c_starve_max)
            w_streak_nxt = r_streak + 4'd1;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack || w_timeout) begin
          w_state_nxt = IDLE;
          w_if_done   = ~bus.if_flush;
        end else if (bus.if_flush) begin
          w_state_nxt = DROP;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack || w_timeout) begin
          w_state_nxt = IDLE;
          w_dm_done   = 1'b1;
        end
      end
      DROP: begin
        // The memory cannot abort, so the cancelled read is drained silently
        if (bus.mem_ack || w_timeout)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_streak <= 4'd0;
      r_addr   <= 32'd0;
      r_we     <= 1'b0;
      r_wstrb  <= 4'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      if (w_grant_if) begin
        r_addr  <= bus.if_addr;
        r_we    <= 1'b0;
        r_wstrb <= 4'd0;
        r_wdata <= 32'd0;
      end else if (w_grant_dm) begin
        r_addr  <= bus.dm_addr;
        r_we    <= bus.dm_we;
        r_wstrb <= bus.dm_wstrb;
        r_wdata <= bus.dm_wdata;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int                  c_wdog_w   = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_wdog_w-1:0] c_wdog_lim = c_wdog_w'(WDOG_CYCLES);

  logic [c_wdog_w-1:0] r_wdog;
  logic                r_bus_err;

  assign w_timeout = w_busy && !bus.mem_ack && (r_wdog == c_wdog_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_grant_if || w_grant_dm)
        r_wdog <= '0;
      else if (w_busy && !bus.mem_ack && r_wdog != c_wdog_lim)
        r_wdog <= r_wdog + 1'b1;
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign bus.mem_req   = w_busy;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_we    = r_we;
  assign bus.mem_wstrb = r_wstrb;
  assign bus.mem_wdata = r_wdata;

  assign bus.if_ready  = w_if_done;
  assign bus.if_rdata  = w_if_done ? (w_timeout ? c_nop : bus.mem_rdata) : 32'd0;
  assign bus.dm_ready  = w_dm_done;
  assign bus.dm_rdata  = w_dm_done ? (w_timeout ? c_nop : bus.mem_rdata) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arb : directed and random checks of mem_port_arb against a
// transaction-level reference model.                                Rev 1.0
// ============================================================================
module tb_mem_port_arb;
  localparam int          STARVE = 4;
  localparam int          WDOG   = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_err;

  mem_port_arb_if bus ();

  mem_port_arb #(.FETCH_STARVE_MAX(STARVE), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: one outstanding memory transaction and its owner
  bit          m_busy, m_dm, m_cancel, m_err, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_run, m_wait, lat_left;
  bit          e_if_ready, e_dm_ready, o_if_ready, o_dm_ready;
  logic [31:0] o_if_rdata, o_dm_rdata;
  bit          grants[$];
  logic [31:0] mem_arr[256];

  // Random requester state
  bit          f_pend, d_pend, d_we, fl_now;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wstrb = 4'd0;
    bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
  endtask

  task automatic model_clear();
    m_busy = 0; m_dm = 0; m_cancel = 0; m_err = 0; m_run = 0; m_wait = 0;
  endtask

  // Observe one cycle with the inputs already applied, then advance the model
  task automatic step();
    bit ack, fl, tmo, done, ifc;
    logic [31:0] exp_rd;
    #1;
    ack = bus.mem_ack;
    fl  = bus.if_flush;
    tmo = 0;
`ifdef ARB_WATCHDOG_EN
    tmo = m_busy && !ack && (m_wait == WDOG);
`endif
    done       = m_busy && (ack || tmo);
    e_if_ready = done && !m_dm && !m_cancel && !fl;
    e_dm_ready = done && m_dm;
    exp_rd     = tmo ? NOP : bus.mem_rdata;
    o_if_ready = bus.if_ready;
    o_dm_ready = bus.dm_ready;
    o_if_rdata = bus.if_rdata;
    o_dm_rdata = bus.dm_rdata;

    check("mem_req", 32'(bus.mem_req), 32'(m_busy));
    check("if_ready", 32'(bus.if_ready), 32'(e_if_ready));
    check("dm_ready", 32'(bus.dm_ready), 32'(e_dm_ready));
    check("bus_err", 32'(bus_err), 32'(m_err));
    if (m_busy) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", 32'(bus.mem_we), 32'(m_we));
      check("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
      if (m_dm && m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (e_if_ready) check("if_rdata", bus.if_rdata, exp_rd);
    if (e_dm_ready && !m_we) check("dm_rdata", bus.dm_rdata, exp_rd);

    if (m_busy) begin
      if (done) begin
        m_busy = 0;
        if (tmo) m_err = 1;
      end else begin
        m_wait++;
        if (!m_dm && fl) m_cancel = 1;
        if (lat_left > 0) lat_left--;
      end
    end else begin
      ifc = bus.if_req && !fl;
      if (ifc && (!bus.dm_req || m_run == STARVE)) begin
        m_dm = 0; m_addr = bus.if_addr; m_we = 0; m_wstrb = 4'd0; m_wdata = 32'd0;
        m_run = 0; m_busy = 1;
        grants.push_back(1'b0);
      end else if (bus.dm_req) begin
        m_dm = 1; m_addr = bus.dm_addr; m_we = bus.dm_we;
        m_wstrb = bus.dm_wstrb; m_wdata = bus.dm_wdata;
        m_run = bus.if_req ? ((m_run < STARVE) ? m_run + 1 : STARVE) : 0;
        m_busy = 1;
        grants.push_back(1'b1);
      end
      if (m_busy) begin
        m_cancel = 0; m_wait = 0; lat_left = int'($urandom_range(0, 3));
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_if_ready"}, 32'(bus.if_ready), 32'd0);
    check({tag, "_dm_ready"}, 32'(bus.dm_ready), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_order[6];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    lat_left = 0;
    model_clear();
    do_reset();

    // Fetch only, latency 3
    set_idle(); bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step();
    check("t1_mem_req_c1", 32'(bus.mem_req), 32'd1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    repeat (3) step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
    step();
    check("t1_if_ready", 32'(o_if_ready), 32'd1);
    check("t1_if_rdata", o_if_rdata, 32'h0050_0093);
    set_idle(); step();

    // Store and fetch requested together: data first
    grants.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_wstrb = 4'b0011;
    bus.dm_addr = 32'h2004; bus.dm_wdata = 32'hDEAD_BEEF;
    step();
    check("t2_mem_we", 32'(bus.mem_we), 32'd1);
    check("t2_mem_wstrb", 32'(bus.mem_wstrb), 32'b0011);
    check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.mem_ack = 1'b1; step();
    check("t2_dm_ready", 32'(o_dm_ready), 32'd1);
    bus.dm_req = 1'b0; bus.mem_ack = 1'b0; step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678; step();
    check("t2_if_ready", 32'(o_if_ready), 32'd1);
    set_idle(); step();
    check("t2_grant_count", 32'(grants.size()), 32'd2);
    check("t2_grant0_dm", 32'(grants[0]), 32'd1);
    check("t2_grant1_if", 32'(grants[1]), 32'd0);

    // Starvation guard with both requests held
    grants.delete();
    for (int i = 0; i < 30; i++) begin
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
      bus.mem_ack = m_busy; bus.mem_rdata = mem_arr[8'h00];
      step();
    end
    set_idle(); step();
    check("t3_grant_count", 32'(grants.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      check($sformatf("t3_grant%0d", k), 32'(grants[k]), 32'(exp_order[k]));
    if (m_busy) begin bus.mem_ack = 1'b1; step(); set_idle(); step(); end

    // Flush during fetch, ack three cycles later
    set_idle(); bus.if_req = 1'b1; bus.if_addr = 32'h500; step();
    step();
    bus.if_flush = 1'b1; step();
    set_idle(); step();
    step();
    check("t4_drop_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555; step();
    check("t4_no_if_ready", 32'(o_if_ready), 32'd0);
    set_idle(); bus.if_req = 1'b1; bus.if_addr = 32'h600; step();
    check("t4_regrant", 32'(bus.mem_req), 32'd1);
    check("t4_regrant_addr", bus.mem_addr, 32'h600);
    bus.mem_ack = 1'b1; step();
    set_idle(); step();

    // Flush coincident with ack
    bus.if_req = 1'b1; bus.if_addr = 32'h640; step();
    step();
    bus.mem_ack = 1'b1; bus.if_flush = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD; step();
    check("t4b_no_if_ready", 32'(o_if_ready), 32'd0);
    check("t4b_idle", 32'(bus.mem_req), 32'd0);
    set_idle(); step();

    // Asynchronous reset in the middle of a data access
    bus.dm_req = 1'b1; bus.dm_addr = 32'h40; step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    rst_n = 1'b0;
    #1;
    check("t5_mem_req", 32'(bus.mem_req), 32'd0);
    check("t5_dm_ready", 32'(bus.dm_ready), 32'd0);
    model_clear();
    set_idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h44; step();
    check("t5_regrant", 32'(bus.mem_req), 32'd1);
    check("t5_regrant_addr", bus.mem_addr, 32'h44);
    bus.mem_ack = 1'b1; bus.mem_rdata = mem_arr[8'h11]; step();
    check("t5_dm_ready_after", 32'(o_dm_ready), 32'd1);
    check("t5_dm_rdata", o_dm_rdata, mem_arr[8'h11]);
    set_idle(); step();

`ifdef ARB_WATCHDOG_EN
    // Fetch that the memory never acknowledges
    bus.if_req = 1'b1; bus.if_addr = 32'h700; step();
    repeat (8) step();
    step();
    check("t6_if_ready", 32'(o_if_ready), 32'd1);
    check("t6_if_rdata", o_if_rdata, NOP);
    set_idle();
    check("t6_bus_err", 32'(bus_err), 32'd1);
    repeat (3) step();
    check("t6_bus_err_sticky", 32'(bus_err), 32'd1);
    do_reset();
`else
    // Without the watchdog an unacknowledged access simply waits
    bus.if_req = 1'b1; bus.if_addr = 32'h700; step();
    repeat (20) step();
    check("t6_still_waiting", 32'(bus.mem_req), 32'd1);
    check("t6_no_bus_err", 32'(bus_err), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1111; step();
    check("t6_late_ready", 32'(o_if_ready), 32'd1);
    set_idle(); step();
`endif

    // Randomised traffic
    f_pend = 0; d_pend = 0;
    f_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; d_we = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) begin
        f_pend = 1; f_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom); d_wstrb = 4'($urandom);
        d_addr = {22'd0, 8'($urandom), 2'b00}; d_wdata = $urandom;
      end
      bus.if_req = f_pend; bus.if_addr = f_addr;
      bus.if_flush = ($urandom_range(0, 9) == 0);
      bus.dm_req = d_pend; bus.dm_we = d_we; bus.dm_wstrb = d_wstrb;
      bus.dm_addr = d_addr; bus.dm_wdata = d_wdata;
      if (m_busy) begin
        bus.mem_ack = (lat_left == 0);
        bus.mem_rdata = (m_dm && m_we) ? $urandom : mem_arr[m_addr[9:2]];
      end else begin
        bus.mem_ack = ($urandom_range(0, 15) == 0);
        bus.mem_rdata = $urandom;
      end
      fl_now = bus.if_flush;
      step();
      if (e_if_ready || fl_now) f_pend = 0;
      if (e_dm_ready) begin
        d_pend = 0;
        if (m_we)
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mem_arr[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
